ftq_core: RTL
=============

Name: ftq_core

Overview:
- Fetch target queue between the BPU and the icache.
- Accepts one predicted fetch block per cycle from the BPU and stores it in an entry of type ftqInfo_t.
- Issues blocks in order to the icache as ftq2icacheInfo_t.
- On in-order commit from the backend, retires the head entry and emits a registered BPupdateInfo_t that trains the FTB.

Parameters:
- DEPTH, 16, number of queue entries; must be a power of 2, at least 4.
- IDXW, $clog2(DEPTH), width of an entry index.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- i_pred_vld  in  1  BPU presents a prediction.
- o_pred_rdy  out  1  the queue can accept a prediction.
- i_pred_info  in  ftqInfo_t  predicted block: start, end, taken, target, FTB meta.
- o_fetch_vld  out  1  a fetch request is valid.
- i_fetch_rdy  in  1  icache accepts the request.
- o_fetch_info  out  ftq2icacheInfo_t  start address and block size.
- o_fetch_idx  out  IDXW  queue index of the issued entry.
- i_commit_vld  in  1  backend retires the oldest entry.
- i_commit_taken  in  1  resolved direction of the block's branch.
- i_commit_target  in  `XDEF  resolved branch target.
- i_flush  in  1  backend redirect; discard all live entries.
- o_update_vld  out  1  FTB update valid.
- o_update_info  out  BPupdateInfo_t  FTB training data.
- o_empty  out  1  no live entries.

Behaviour:
- Storage: DEPTH-entry ftqInfo_t array.
- Pointers: wr_ptr, fetch_ptr and cmt_ptr, each IDXW+1 bits (extra wrap bit).
- Entry count is wr_ptr − cmt_ptr. Full when the index bits are equal and the wrap bits differ. Empty when the pointers are equal.
- Reset (rst=1, sampled at the clk edge):
  - All pointers are 0 and the update register is cleared.
  - Outputs: o_pred_rdy=1, o_fetch_vld=0, o_fetch_idx=0, o_update_vld=0, o_update_info=0, o_empty=1.
  - Entry storage is not cleared.
- Enqueue:
  - o_pred_rdy = !full.
  - When i_pred_vld && o_pred_rdy, write array[wr_ptr] and increment wr_ptr.
  - The new entry is visible at the fetch port in the next cycle. There is no same-cycle bypass.
- Fetch:
  - o_fetch_vld = (fetch_ptr != wr_ptr) && !i_flush.
  - o_fetch_info.startAddr = entry.startAddr.
  - fetchBlock_size = (entry.endAddr − entry.startAddr), truncated to `SDEF(`FTB_PREDICT_WIDTH)`.
  - The BPU guarantees fetchBlock_size ≤ FTB_PREDICT_WIDTH. The queue does not check it.
  - On the handshake, increment fetch_ptr.
  - Outputs are combinational from registered state and are held stable while o_fetch_vld && !i_fetch_rdy.
- Commit:
  - When i_commit_vld, retire array[cmt_ptr] and increment cmt_ptr.
  - i_commit_vld with cmt_ptr == fetch_ptr (entry not yet fetched) is illegal; flag it with an assertion.
  - One cycle after a commit, o_update_vld=1 with these fields:
    - startAddr = entry.startAddr.
    - carry = (endAddr[XLEN-1:FALLTHRU_WIDTH+1] != startAddr[same bits]).
    - fallthruAddr = endAddr[FALLTHRU_WIDTH:1].
    - targetAddr = i_commit_target[TARGET_WIDTH:1].
    - tarStat = calcuTarStat(startAddr, i_commit_target).
    - branch_type = entry.branch_type.
    - counter = counterUpdate(hit_on_ftb ? entry.ftb_counter : 2'b01, i_commit_taken).
  - o_update_vld stays high for exactly one cycle per commit.
- Flush:
  - On i_flush, wr_ptr and fetch_ptr are set to the value cmt_ptr takes after any same-cycle commit.
  - An enqueue in the flush cycle is dropped.
  - A commit in the flush cycle is applied first and still produces its update.
  - A pending update register is unaffected by flush.
- Simultaneous enqueue and commit when full: enqueue is refused, because rdy is computed from the pre-commit count.
- Pointer wrap: the index wraps modulo DEPTH and the wrap bit toggles.

Decomposition:
- Add to the frontend shared package:
  - ftqIdx_t (IDXW+1 bits with wrap bit).
  - ftqFuncs::isFull and ftqFuncs::isEmpty.
  - A function building ftbInfo_t from an ftqInfo_t plus the commit result.
- Reuse ftbFuncs::calcuTarStat and ftbFuncs::counterUpdate.
- One natural sub-module: ftq_ptr, a wrap-bit pointer register with inc and load.

Test Plan:
1. Reset, then 3 predictions at startAddr 0x1000/0x1010/0x1020 with endAddr +0x10 and i_fetch_rdy=1 → fetches in order one cycle after each enqueue, size=0x10, o_fetch_idx 0,1,2.
2. Fill with DEPTH=16 entries and i_fetch_rdy=0 → o_pred_rdy=0 after the 16th enqueue. Commit blocked because nothing is fetched. Then fetch 1 and commit 1 → o_pred_rdy=1.
3. Entry with start=0x1000, hit_on_ftb=1, counter=2; commit with taken=1, target=0x1000+(1<<(TARGET_WIDTH+1)) → next cycle update has counter=3, tarStat=OVF, targetAddr=0.
4. Entry with hit_on_ftb=0; commit with taken=0 → update counter=0. Entry with endAddr crossing the 2^(FALLTHRU_WIDTH+1) boundary → carry=1.
5. 5 live entries, 2 fetched; i_flush together with i_commit_vld → update for the committed entry. In the next cycle o_empty=1 and o_fetch_vld=0, and a concurrent enqueue is dropped.
6. 40 enqueue/fetch/commit cycles with random stalls → pointers wrap twice, order preserved, no loss or duplication (scoreboard).

Source files
------------

// File: rtl/ftq_core_pkg.sv
// ---------------------------------------------------------------------------
// ftq_core_pkg: shared frontend types and helpers for the fetch target queue
// and the FTB training path.
//   - ftqInfo_t         : one predicted fetch block as produced by the BPU
//   - ftq2icacheInfo_t  : fetch request sent to the icache
//   - ftbInfo_t         : compressed FTB entry fields rebuilt at commit time
//   - BPupdateInfo_t    : FTB update (start address + ftbInfo_t)
//   - ftqIdx_t          : queue pointer with an extra wrap bit
// Helpers: isFull / isEmpty (wrap-bit pointer compare), calcuTarStat,
// counterUpdate, buildFtbInfo.
// ---------------------------------------------------------------------------
package ftq_core_pkg;

  localparam int XLEN              = 32;
  localparam int FTB_PREDICT_WIDTH = 16;
  localparam int SZW               = $clog2(FTB_PREDICT_WIDTH) + 1;
  localparam int FALLTHRU_WIDTH    = 4;
  localparam int TARGET_WIDTH      = 11;
  localparam int FTQ_DEPTH         = 16;
  localparam int FTQ_IDXW          = $clog2(FTQ_DEPTH);
  // Width of the address bits above the stored target field.
  localparam int TAR_HIW           = XLEN - TARGET_WIDTH - 1;

  typedef logic [FTQ_IDXW:0] ftqIdx_t;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_COND = 2'd1,
    BR_JAL  = 2'd2,
    BR_JALR = 2'd3
  } br_type_e;

  // Relation of the target's upper bits to the block start's upper bits.
  typedef enum logic [1:0] {
    TAR_FIT = 2'd0,
    TAR_OVF = 2'd1,
    TAR_UDF = 2'd2,
    TAR_FAR = 2'd3
  } tar_stat_e;

  typedef struct packed {
    logic [XLEN-1:0] startAddr;
    logic [XLEN-1:0] endAddr;
    logic            taken;
    logic [XLEN-1:0] target;
    br_type_e        branch_type;
    logic            hit_on_ftb;
    logic [1:0]      ftb_counter;
  } ftqInfo_t;

  typedef struct packed {
    logic [XLEN-1:0] startAddr;
    logic [SZW-1:0]  fetchBlock_size;
  } ftq2icacheInfo_t;

  typedef struct packed {
    logic                      carry;
    logic [FALLTHRU_WIDTH-1:0] fallthruAddr;
    logic [TARGET_WIDTH-1:0]   targetAddr;
    tar_stat_e                 tarStat;
    br_type_e                  branch_type;
    logic [1:0]                counter;
  } ftbInfo_t;

  typedef struct packed {
    logic [XLEN-1:0] startAddr;
    ftbInfo_t        ftb;
  } BPupdateInfo_t;

  // Pointers are passed zero-extended to 32 bits so one helper serves any
  // queue depth; idxw is the number of index bits below the wrap bit.
  function automatic logic isFull(input logic [31:0] wr, input logic [31:0] cmt,
                                  input int idxw);
    logic [31:0] mask;
    mask = (32'd2 << idxw) - 32'd1;
    return ((wr ^ cmt) & mask) == (32'd1 << idxw);
  endfunction

  function automatic logic isEmpty(input logic [31:0] a, input logic [31:0] b);
    return a == b;
  endfunction

  function automatic tar_stat_e calcuTarStat(input logic [XLEN-1:0] pc,
                                             input logic [XLEN-1:0] tgt);
    logic [TAR_HIW-1:0] hp;
    logic [TAR_HIW-1:0] ht;
    hp = pc[XLEN-1:TARGET_WIDTH+1];
    ht = tgt[XLEN-1:TARGET_WIDTH+1];
    if (ht == hp)                        return TAR_FIT;
    else if (ht == hp + TAR_HIW'(1))     return TAR_OVF;
    else if (ht == hp - TAR_HIW'(1))     return TAR_UDF;
    else                                 return TAR_FAR;
  endfunction

  // 2-bit saturating direction counter.
  function automatic logic [1:0] counterUpdate(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == 2'b11) ? ctr : ctr + 2'b01;
    else       return (ctr == 2'b00) ? ctr : ctr - 2'b01;
  endfunction

  function automatic ftbInfo_t buildFtbInfo(input ftqInfo_t e, input logic taken,
                                            input logic [XLEN-1:0] tgt);
    ftbInfo_t f;
    f.carry        = e.endAddr[XLEN-1:FALLTHRU_WIDTH+1] != e.startAddr[XLEN-1:FALLTHRU_WIDTH+1];
    f.fallthruAddr = e.endAddr[FALLTHRU_WIDTH:1];
    f.targetAddr   = tgt[TARGET_WIDTH:1];
    f.tarStat      = calcuTarStat(e.startAddr, tgt);
    f.branch_type  = e.branch_type;
    // A block that missed in the FTB starts from weakly-not-taken.
    f.counter      = counterUpdate(e.hit_on_ftb ? e.ftb_counter : 2'b01, taken);
    return f;
  endfunction

endpackage

// File: rtl/ftq_core_ptr.sv
// ---------------------------------------------------------------------------
// ftq_ptr: queue pointer register with an extra wrap bit.
//   clk, rst    : clock, synchronous active-high reset (pointer -> 0)
//   i_inc       : advance by one (index wraps, wrap bit toggles naturally)
//   i_load      : overwrite with i_load_val; wins over i_inc
//   i_load_val  : value to load
//   o_ptr       : current pointer
// ---------------------------------------------------------------------------
module ftq_ptr #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic [W-1:0] o_ptr
);

  logic [W-1:0] r_ptr;

  always_ff @(posedge clk) begin
    if (rst)         r_ptr <= '0;
    else if (i_load) r_ptr <= i_load_val;
    else if (i_inc)  r_ptr <= r_ptr + W'(1);
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/ftq_core.sv
// ---------------------------------------------------------------------------
// ftq_core: fetch target queue between the BPU and the icache.
// Predicted fetch blocks are enqueued, issued in order to the icache, and
// retired in order on backend commit, which produces a registered FTB update.
//
// Handshakes: a transfer happens in a cycle where valid && ready are both
// high at the clock edge. Valid never depends on the partner's ready; the
// fetch request is held stable while o_fetch_vld && !i_fetch_rdy. Commit has
// no ready: i_commit_vld alone retires the head entry.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   i_pred_vld/o_pred_rdy         BPU prediction handshake
//   i_pred_info                   predicted block (ftqInfo_t)
//   o_fetch_vld/i_fetch_rdy       icache request handshake
//   o_fetch_info, o_fetch_idx     request payload and its queue index
//   i_commit_vld/_taken/_target   in-order retire of the oldest entry
//   i_flush                       drop all live entries
//   o_update_vld, o_update_info   one-cycle FTB update after each commit
//   o_empty                       no live entries
// ---------------------------------------------------------------------------
module ftq_core
  import ftq_core_pkg::*;
#(
  parameter int DEPTH = FTQ_DEPTH,
  localparam int IDXW = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_pred_vld,
  output logic            o_pred_rdy,
  input  ftqInfo_t        i_pred_info,
  output logic            o_fetch_vld,
  input  logic            i_fetch_rdy,
  output ftq2icacheInfo_t o_fetch_info,
  output logic [IDXW-1:0] o_fetch_idx,
  input  logic            i_commit_vld,
  input  logic            i_commit_taken,
  input  logic [XLEN-1:0] i_commit_target,
  input  logic            i_flush,
  output logic            o_update_vld,
  output BPupdateInfo_t   o_update_info,
  output logic            o_empty
);

  ftqInfo_t r_mem [DEPTH];

  logic [IDXW:0]   w_wr_ptr;
  logic [IDXW:0]   w_fetch_ptr;
  logic [IDXW:0]   w_cmt_ptr;
  logic [IDXW:0]   w_cmt_next;
  logic            w_full;
  logic            w_enq;
  logic            w_fetch_hs;
  logic [XLEN-1:0] w_blk_size;

  logic            r_update_vld;
  BPupdateInfo_t   r_update_info;

  // Readiness uses the pre-commit occupancy, so a same-cycle commit on a full
  // queue does not open a slot until the next cycle.
  assign w_full     = isFull(32'(w_wr_ptr), 32'(w_cmt_ptr), IDXW);
  assign o_pred_rdy = !w_full;
  assign w_enq      = i_pred_vld && !w_full && !i_flush;
  assign o_empty    = isEmpty(32'(w_wr_ptr), 32'(w_cmt_ptr));

  assign o_fetch_vld = !isEmpty(32'(w_fetch_ptr), 32'(w_wr_ptr)) && !i_flush;
  assign w_fetch_hs  = o_fetch_vld && i_fetch_rdy;
  assign o_fetch_idx = w_fetch_ptr[IDXW-1:0];

  // The BPU bounds the block length, so truncation to SZW bits is exact.
  assign w_blk_size                   = r_mem[w_fetch_ptr[IDXW-1:0]].endAddr
                                        - r_mem[w_fetch_ptr[IDXW-1:0]].startAddr;
  assign o_fetch_info.startAddr       = r_mem[w_fetch_ptr[IDXW-1:0]].startAddr;
  assign o_fetch_info.fetchBlock_size = w_blk_size[SZW-1:0];

  // Flush rewinds writer and fetcher to where the head lands after any
  // same-cycle commit.
  assign w_cmt_next = w_cmt_ptr + (IDXW+1)'(i_commit_vld);

  ftq_ptr #(.W(IDXW+1)) u_wr_ptr (
    .clk        (clk),
    .rst        (rst),
    .i_inc      (w_enq),
    .i_load     (i_flush),
    .i_load_val (w_cmt_next),
    .o_ptr      (w_wr_ptr)
  );

  ftq_ptr #(.W(IDXW+1)) u_fetch_ptr (
    .clk        (clk),
    .rst        (rst),
    .i_inc      (w_fetch_hs),
    .i_load     (i_flush),
    .i_load_val (w_cmt_next),
    .o_ptr      (w_fetch_ptr)
  );

  ftq_ptr #(.W(IDXW+1)) u_cmt_ptr (
    .clk        (clk),
    .rst        (rst),
    .i_inc      (i_commit_vld),
    .i_load     (1'b0),
    .i_load_val ('0),
    .o_ptr      (w_cmt_ptr)
  );

  // Entry storage carries no reset; only pointers define liveness.
  always_ff @(posedge clk) begin
    if (w_enq) r_mem[w_wr_ptr[IDXW-1:0]] <= i_pred_info;
  end

  // The update register ignores flush so a commit in the flush cycle still
  // trains the FTB.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_update_vld  <= 1'b0;
      r_update_info <= '0;
    end else begin
      r_update_vld <= i_commit_vld;
      if (i_commit_vld) begin
        r_update_info.startAddr <= r_mem[w_cmt_ptr[IDXW-1:0]].startAddr;
        r_update_info.ftb       <= buildFtbInfo(r_mem[w_cmt_ptr[IDXW-1:0]],
                                                i_commit_taken, i_commit_target);
      end
    end
  end

  assign o_update_vld  = r_update_vld;
  assign o_update_info = r_update_info;

  // The backend may only retire an entry that has already been issued.
  a_commit_fetched: assert property (@(posedge clk) disable iff (rst)
    i_commit_vld |-> (w_cmt_ptr != w_fetch_ptr));

endmodule
